// File: rtl/microcode_rom.sv
// Read-only 256 x 40-bit microcode store for the multi-cycle CPU control path.
// The control word is registered on the rising edge; reset clears it asynchronously.
module microcode_rom (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  address,
    output logic [39:0] data
);

    // Decode-phase no-op: skip straight back to FETCH.
    localparam logic [39:0] DecodeNop = 40'h00_0000_0010;

    logic [39:0] rom_word;

    always_comb begin
        rom_word = 40'h00_0000_0000;
        if (address < 8'd64) begin
            rom_word = DecodeNop;
        end
        case (address)
            8'd0:    rom_word = 40'h10_89A0_0010;  // reg-reg add
            8'd1:    rom_word = 40'h10_00A0_9010;  // load imm10
            8'd2:    rom_word = 40'hC4_0000_0000;  // fetch
            8'd3:    rom_word = 40'h00_0000_0000;  // null word
            8'd4:    rom_word = 40'h80_8000_1000;  // load, address phase
            8'd68:   rom_word = 40'h20_0000_0000;  // load, read phase
            8'd132:  rom_word = 40'h10_00A4_0000;  // load, writeback from MDR
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= 40'h00_0000_0000;
        end else begin
            data <= rom_word;
        end
    end

endmodule

// File: tb/tb_microcode_rom.sv
// Self-checking bench for microcode_rom: directed steps plus random reads against a
// table-based reference of the microcode contents.
module tb_microcode_rom;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  address = 8'd0;
    logic [39:0] data;

    int checks = 0;
    int fails  = 0;

    logic [39:0] model [256];

    microcode_rom dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data    (data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] exp);
        checks++;
        assert (data === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, data, exp);
        end
    endtask

    // Present addr at a falling edge, sample just after the next rising edge.
    task automatic step(input logic [7:0] addr, input string tag);
        @(negedge clk);
        address = addr;
        @(posedge clk);
        #1;
        chk(tag, model[addr]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = (i < 64) ? 40'h00_0000_0010 : 40'h0;
        model[0]   = 40'h10_89A0_0010;
        model[1]   = 40'h10_00A0_9010;
        model[2]   = 40'hC4_0000_0000;
        model[3]   = 40'h00_0000_0000;
        model[4]   = 40'h80_8000_1000;
        model[68]  = 40'h20_0000_0000;
        model[132] = 40'h10_00A4_0000;

        // Asynchronous reset before any rising edge.
        address = 8'd2;
        #1 reset = 1'b1;
        #1 chk("reset_async", 40'h0);
        repeat (2) @(posedge clk);
        #1 chk("reset_hold", 40'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("first_after_reset", 40'hC4_0000_0000);

        step(8'd0,   "addr0");
        step(8'd1,   "addr1");
        step(8'd4,   "addr4");
        step(8'd68,  "addr68");
        step(8'd132, "addr132");
        step(8'd50,  "addr50");
        step(8'd100, "addr100");
        step(8'd150, "addr150");
        step(8'd200, "addr200");
        step(8'd255, "addr255");

        // Address change between edges must not reach data until the next rising edge.
        step(8'd2, "mid_pre");
        @(negedge clk);
        address = 8'd0;
        #2 chk("mid_hold", 40'hC4_0000_0000);
        @(posedge clk);
        #1 chk("mid_after", 40'h10_89A0_0010);

        // Full sweep with a reset pulse in the middle.
        for (int a = 0; a < 256; a++) begin
            step(a[7:0], "sweep");
            checks++;
            assert (data[33] === 1'b0 && data[2:0] === 3'b000) else begin
                fails++;
                $error("FAIL sweep_reserved: observed %h expected bits33,2:0 zero", data);
            end
            if (a == 128) begin
                #2 reset = 1'b1;
                #1 chk("sweep_reset", 40'h0);
                @(negedge clk);
                reset = 1'b0;
                #1 chk("sweep_reset_low", 40'h0);
            end
        end

        // Random reads with occasional asynchronous reset pulses.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(19) == 0) begin
                @(negedge clk);
                #2 reset = 1'b1;
                #1 chk("rand_reset", 40'h0);
                #1 reset = 1'b0;
            end
            step(8'($urandom_range(255)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
